// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a fall-through FIFO in fixed-size bursts onto a valid/ready stream tagged with last
// Ports:
//   i_Clk, i_Rst_Sync_L                          clock, synchronous active-low reset
//   o_FIFO_Rd_En, i_FIFO_Rd_Data, i_FIFO_Count   FIFO read port (pop strobe, head word, occupancy)
//   o_Valid, o_Data, o_Last, i_Ready             output stream, o_Last marks final word of a burst
//   o_Busy                                       high while a burst is in progress
module fifo_burst_reader #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_Sync_L,
    output logic                   o_FIFO_Rd_En,
    input  logic [WIDTH-1:0]       i_FIFO_Rd_Data,
    input  logic [$clog2(DEPTH):0] i_FIFO_Count,
    output logic                   o_Valid,
    output logic [WIDTH-1:0]       o_Data,
    output logic                   o_Last,
    input  logic                   i_Ready,
    output logic                   o_Busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] BL_C = CW'(BURST_LEN);
    localparam logic [RW-1:0] BL_R = RW'(BURST_LEN);
    localparam logic [TW-1:0] TO   = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] remaining;
    logic [TW-1:0] tmo;
    logic          start, accept;

    // a full burst and a timed-out partial burst start the same way
    assign start  = (i_FIFO_Count >= BL_C) || (tmo == TO && i_FIFO_Count != '0);
    assign accept = o_Valid & i_Ready;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_Sync_L)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state == IDLE  ? (start ? BURST : IDLE) :
                    state == BURST ? (o_FIFO_Rd_En && remaining == RW'(1) ? DRAIN : BURST) :
                                     (accept ? IDLE : DRAIN);
    end

    // the count guard keeps the pop independent of any FIFO empty flag
    always_comb begin
        o_FIFO_Rd_En = state == BURST && remaining != '0 && i_FIFO_Count != '0 && (!o_Valid || i_Ready);
        o_Busy       = state != IDLE;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_Sync_L) begin
            o_Valid   <= 1'b0;
            o_Last    <= 1'b0;
            o_Data    <= '0;
            remaining <= '0;
            tmo       <= '0;
        end else begin
            tmo <= (state != IDLE || start || i_FIFO_Count == '0) ? '0 : tmo + TW'(tmo != TO);
            if (state == IDLE && start)
                remaining <= i_FIFO_Count < BL_C ? RW'(i_FIFO_Count) : BL_R;
            else if (o_FIFO_Rd_En)
                remaining <= remaining - RW'(1);
            if (o_FIFO_Rd_En) begin
                o_Data  <= i_FIFO_Rd_Data;
                o_Valid <= 1'b1;
                o_Last  <= remaining == RW'(1);
            end else if (accept) begin
                o_Valid <= 1'b0;
                o_Last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: self-checking bench for fifo_burst_reader with a behavioural FIFO and a data scoreboard
module tb_fifo_burst_reader;
    logic       i_Clk = 1'b0;
    logic       i_Rst_Sync_L;
    logic       o_FIFO_Rd_En;
    logic [7:0] i_FIFO_Rd_Data;
    logic [4:0] i_FIFO_Count;
    logic       o_Valid;
    logic [7:0] o_Data;
    logic       o_Last;
    logic       i_Ready;
    logic       o_Busy;

    logic       fl, wr;
    logic [7:0] wd;
    logic [7:0] mem [16];
    logic [3:0] rp, wp;
    logic [4:0] cnt;
    logic       rd_ok;

    int         compared = 0, mismatched = 0;
    logic [7:0] sb [$];
    int         acc_n, last_n;
    logic [7:0] last_d;
    logic [15:0] lmask;
    int         idle, seen, first;

    always #5 i_Clk = ~i_Clk;

    fifo_burst_reader dut (
        .i_Clk(i_Clk), .i_Rst_Sync_L(i_Rst_Sync_L), .o_FIFO_Rd_En(o_FIFO_Rd_En),
        .i_FIFO_Rd_Data(i_FIFO_Rd_Data), .i_FIFO_Count(i_FIFO_Count), .o_Valid(o_Valid),
        .o_Data(o_Data), .o_Last(o_Last), .i_Ready(i_Ready), .o_Busy(o_Busy)
    );

    assign rd_ok          = o_FIFO_Rd_En && cnt != 5'd0;
    assign i_FIFO_Rd_Data = mem[rp];
    assign i_FIFO_Count   = cnt;

    always @(posedge i_Clk) begin
        if (fl) begin
            rp  <= 4'd0;
            wp  <= 4'd0;
            cnt <= 5'd0;
        end else begin
            if (wr) begin
                mem[wp] <= wd;
                wp      <= wp + 4'd1;
            end
            if (rd_ok) rp <= rp + 4'd1;
            cnt <= cnt + 5'(wr) - 5'(rd_ok);
        end
    end

    typedef struct {
        logic       rdy;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       re;
        logic       b;
    } vec_t;
    vec_t tv [7];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step();
        logic       acc;
        logic [7:0] d;
        logic       l;
        acc = i_Rst_Sync_L && o_Valid && i_Ready;
        d   = o_Data;
        l   = o_Last;
        @(posedge i_Clk);
        @(negedge i_Clk);
        if (acc) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL sb_empty: got %0h expected no word", d);
            end else
                chk("sb_data", 32'(d), 32'(sb.pop_front()));
            if (acc_n < 16) lmask[acc_n[3:0]] = l;
            if (l) begin
                last_n++;
                last_d = d;
            end
            acc_n++;
        end
    endtask

    task automatic put(input logic [7:0] d);
        wr = 1'b1;
        wd = d;
        sb.push_back(d);
        step();
        wr = 1'b0;
    endtask

    task automatic do_reset();
        i_Rst_Sync_L = 1'b0;
        fl = 1'b1;
        step();
        fl = 1'b0;
        sb.delete();
        acc_n  = 0;
        last_n = 0;
        last_d = 8'h00;
        lmask  = 16'h0;
    endtask

    task automatic wait_pop(input string n, input int exp);
        first = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (o_FIFO_Rd_En) begin
                first = k;
                break;
            end
        end
        chk(n, 32'(first), 32'(exp));
    endtask

    task automatic drain(input string n);
        for (int k = 0; k < 20 && o_Busy; k++) step();
        chk(n, 32'(o_Busy), 32'(0));
    endtask

    task automatic trk();
        if (!o_Busy) idle++;
        else begin
            if (seen != 0 && idle > 0) chk("idle_gap", 32'(idle), 32'(1));
            seen = 1;
            idle = 0;
        end
    endtask

    initial begin
        tv[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        tv[1] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1};
        tv[2] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1};
        tv[3] = '{1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1};
        tv[4] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1'b1};
        tv[5] = '{1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0};
        tv[6] = '{1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0};
        i_Ready = 1'b0;
        wr = 1'b0;
        wd = 8'h00;
        @(negedge i_Clk);

        do_reset();
        put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'h55);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_valid", 32'(o_Valid), 32'(0));
            chk("rst_last", 32'(o_Last), 32'(0));
            chk("rst_busy", 32'(o_Busy), 32'(0));
            chk("rst_rden", 32'(o_FIFO_Rd_En), 32'(0));
        end
        i_Rst_Sync_L = 1'b1;
        for (int i = 0; i < 7; i++) begin
            i_Ready = tv[i].rdy;
            step();
            chk("vec_valid", 32'(o_Valid), 32'(tv[i].v));
            chk("vec_data", 32'(o_Data), 32'(tv[i].d));
            chk("vec_last", 32'(o_Last), 32'(tv[i].l));
            chk("vec_rden", 32'(o_FIFO_Rd_En), 32'(tv[i].re));
            chk("vec_busy", 32'(o_Busy), 32'(tv[i].b));
        end
        chk("full_left", 32'(cnt), 32'(1));
        chk("full_accepted", 32'(acc_n), 32'(4));

        do_reset();
        put(8'hA0); put(8'hA1);
        i_Rst_Sync_L = 1'b1;
        wait_pop("tmo_first_pop", 33);
        drain("tmo_busy");
        chk("tmo_accepted", 32'(acc_n), 32'(2));
        chk("tmo_lasts", 32'(last_n), 32'(1));
        chk("tmo_last_word", 32'(last_d), 32'(8'hA1));

        do_reset();
        put(8'hB0); put(8'hB1); put(8'hB2); put(8'hB3);
        i_Ready = 1'b0;
        i_Rst_Sync_L = 1'b1;
        step();
        step();
        chk("bp_first_valid", 32'(o_Valid), 32'(1));
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_data", 32'(o_Data), 32'(8'hB0));
            chk("bp_rden", 32'(o_FIFO_Rd_En), 32'(0));
            chk("bp_one_pop", 32'(cnt), 32'(3));
            step();
        end
        i_Ready = 1'b1;
        first = 0;
        for (int k = 0; k < 10 && o_Busy; k++) begin
            step();
            first++;
        end
        chk("bp_stream_cycles", 32'(first), 32'(4));
        chk("bp_accepted", 32'(acc_n), 32'(4));
        chk("bp_lastmask", 32'(lmask), 32'(16'h0008));

        do_reset();
        put(8'hC0); put(8'hC1); put(8'hC2); put(8'hC3);
        i_Ready = 1'b1;
        i_Rst_Sync_L = 1'b1;
        idle = 0;
        seen = 0;
        for (int k = 4; k < 12; k++) begin
            put(8'(32'hC0 + k));
            trk();
        end
        for (int k = 0; k < 40 && (cnt != 5'd0 || o_Busy); k++) begin
            step();
            trk();
        end
        chk("wr_accepted", 32'(acc_n), 32'(12));
        chk("wr_lastmask", 32'(lmask), 32'(16'h0888));

        do_reset();
        put(8'hD0); put(8'hD1); put(8'hD2); put(8'hD3);
        i_Ready = 1'b1;
        i_Rst_Sync_L = 1'b1;
        step();
        step();
        step();
        i_Rst_Sync_L = 1'b0;
        fl = 1'b1;
        step();
        chk("mid_valid", 32'(o_Valid), 32'(0));
        chk("mid_busy", 32'(o_Busy), 32'(0));
        chk("mid_last", 32'(o_Last), 32'(0));
        fl = 1'b0;
        sb.delete();
        acc_n  = 0;
        last_n = 0;
        lmask  = 16'h0;
        put(8'hE0); put(8'hE1);
        i_Rst_Sync_L = 1'b1;
        wait_pop("mid_first_pop", 33);
        drain("mid_busy_end");
        chk("mid_accepted", 32'(acc_n), 32'(2));
        chk("mid_lastmask", 32'(lmask), 32'(16'h0002));
        chk("mid_sb_empty", 32'(sb.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side controller for the team's register FIFO: drains words out of the FIFO in fixed-size bursts and presents them on a valid/ready output stream, marking the final word of each burst with a last flag.
- Sits between a FIFO's read port (first-word-fall-through data, count output) and a downstream packetiser or UART/SPI transmitter.
- Starts a full burst as soon as enough words are buffered.
- Flushes a partial burst after a programmable idle timeout, so stragglers are never stranded.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, depth of the attached FIFO; sets the count port width to $clog2(DEPTH)+1.
- BURST_LEN, 4, words per full burst; legal range 1..DEPTH.
- TIMEOUT, 32, idle cycles with a non-empty FIFO before a partial burst is flushed; must be at least 1.

Ports:
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst_Sync_L  in  1  synchronous, active-low reset.
- o_FIFO_Rd_En  out  1  FIFO pop strobe; the word on i_FIFO_Rd_Data is consumed this cycle.
- i_FIFO_Rd_Data  in  WIDTH  FIFO head word (fall-through, valid whenever count != 0).
- i_FIFO_Count  in  $clog2(DEPTH)+1  registered FIFO occupancy.
- o_Valid  out  1  output word valid.
- o_Data  out  WIDTH  output word.
- o_Last  out  1  qualifies o_Data as the final word of the current burst.
- i_Ready  in  1  downstream accepts the word when o_Valid and i_Ready are both high.
- o_Busy  out  1  high while a burst is in progress (state != IDLE).

Behaviour:
- Reset is synchronous, active-low.
  - While i_Rst_Sync_L=0 at a clock edge: state=IDLE; o_Valid, o_Last, o_Busy and o_Data all 0; timeout counter 0; remaining counter 0.
  - o_FIFO_Rd_En is 0 combinationally whenever the state is IDLE or DRAIN, so it is 0 during reset.
- Reset mid-burst abandons the burst:
  - Words already popped are lost.
  - No o_Last is issued.
  - The FIFO is not reset by this block.
- States:
  - IDLE.
  - BURST: popping words.
  - DRAIN: all words popped, waiting for the last word to be accepted.
- IDLE:
  - Timeout counter increments each cycle i_FIFO_Count != 0, saturating at TIMEOUT.
  - Timeout counter clears when i_FIFO_Count == 0.
  - Go to BURST when i_FIFO_Count >= BURST_LEN, or when the timeout counter == TIMEOUT and i_FIFO_Count != 0.
  - On that transition, latch remaining = min(i_FIFO_Count, BURST_LEN) and clear the timeout counter.
- Pop rule (combinational, no dependence on any FIFO empty flag, so no combinational loop):
  - o_FIFO_Rd_En = (state==BURST) & (remaining != 0) & (i_FIFO_Count != 0) & (~o_Valid | i_Ready).
- On a pop:
  - o_Data <= i_FIFO_Rd_Data, o_Valid <= 1.
  - remaining decrements.
  - o_Last <= (remaining == 1).
  - If remaining == 1, the state goes to DRAIN.
- Acceptance without a same-cycle pop: o_Valid and o_Last both go to 0.
- o_Valid, o_Data and o_Last stay stable while o_Valid=1 and i_Ready=0.
- DRAIN: when o_Valid & i_Ready, go to IDLE; o_Valid and o_Last go to 0.
- Latency:
  - Start condition sampled at edge N puts the state in BURST.
  - First pop occurs in cycle N+1.
  - o_Valid is high after edge N+1.
- Throughput: 1 word/cycle with i_Ready held high. A pop and an acceptance in the same cycle overlap with no bubble.
- The next burst may start the cycle after returning to IDLE. There is a minimum 1 IDLE cycle between bursts.
- Boundary conditions:
  - Since this block is the only reader, i_FIFO_Count >= remaining throughout BURST; the i_FIFO_Count != 0 term is a safety guard only.
  - Writes arriving during a burst do not extend it; the burst length is fixed at the latch.
  - A FIFO that is exactly at BURST_LEN and also timed out takes a full burst; the two start conditions are identical in effect.
  - BURST_LEN=1: every word is its own burst with o_Last=1.
- Counter widths: remaining is $clog2(BURST_LEN+1) bits; timeout counter is $clog2(TIMEOUT+1) bits; no wrap.

Test Plan:
- **Reset values:** hold i_Rst_Sync_L=0 for 3 cycles with i_FIFO_Count=5 -> o_Valid=0, o_Last=0, o_Busy=0, o_FIFO_Rd_En=0 throughout.
- **Full burst, i_Ready=1:** preload FIFO with 0x11,0x22,0x33,0x44,0x55 -> 4 consecutive o_Valid words 0x11..0x44, o_Last only on 0x44. 0x55 remains in FIFO (count=1), and the timeout counter starts.
- **Timeout flush:** 2 words (0xA0,0xA1) in FIFO, no further writes, TIMEOUT=32 -> no pop for 32 cycles. A burst of 2 then starts, with o_Last on 0xA1, and o_Busy returns to 0 after acceptance.
- **Backpressure:** full burst with i_Ready=0 for 5 cycles after the first o_Valid -> o_Data holds its first value, exactly one pop occurs, and o_FIFO_Rd_En=0 during the stall. After i_Ready is released, the remaining 3 words stream at 1/cycle in order.
- **Writes during burst:** count=4, writes continue every cycle -> the burst is still exactly 4 words with o_Last on the 4th. After 1 IDLE cycle a second burst starts because count >= 4.
- **Mid-burst reset:** assert reset after the 2nd pop of a 4-word burst -> the next cycle shows o_Valid=0 and o_Busy=0. After release with count=2, a new burst starts only after the 32-cycle timeout, and no o_Last is seen for the aborted burst.
